// File: rtl/ltl_report_collector.sv
// Report collector for an LTL automaton cluster: tags masked report hits
// with the causing symbol index and queues them in a FWFT event FIFO.
module ltl_report_collector #(
    parameter int NUM_REPORTS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int IDX_W       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [NUM_REPORTS-1:0]        report_in,
    input  logic [NUM_REPORTS-1:0]        report_mask,
    input  logic                          clear_sticky,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [NUM_REPORTS-1:0]        evt_report,
    output logic [IDX_W-1:0]              evt_index,
    output logic [NUM_REPORTS-1:0]        sticky,
    output logic [15:0]                   overflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [NUM_REPORTS-1:0] report;
        logic [IDX_W-1:0]       index;
    } evt_t;

    evt_t                   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [IDX_W-1:0]       sym_cnt;
    logic [IDX_W-1:0]       idx_d;
    logic                   run_d;

    logic [NUM_REPORTS-1:0] m;
    logic                   hit;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // report_in belongs to the symbol consumed in the previous cycle
    assign m    = report_in & report_mask;
    assign hit  = run_d & (|m);
    assign full = (level == LVL_W'(FIFO_DEPTH));
    assign pop  = evt_valid & evt_ready;
    assign push = hit & (~full | pop);
    assign drop = hit & full & ~pop;

    assign evt_valid  = (level != '0);
    assign evt_report = evt_valid ? mem[rd_ptr].report : '0;
    assign evt_index  = evt_valid ? mem[rd_ptr].index  : '0;
    assign fifo_level = level;
    assign irq        = |sticky;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{report: m, index: idx_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt      <= '0;
            idx_d        <= '0;
            run_d        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            sticky       <= '0;
            overflow_cnt <= '0;
        end else begin
            run_d <= run;
            idx_d <= sym_cnt;
            if (run) begin
                sym_cnt <= sym_cnt + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
            if (drop && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            // a new hit overrides a clear arriving in the same cycle
            sticky <= (clear_sticky ? '0 : sticky) | (hit ? m : '0);
        end
    end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Scoreboard bench for ltl_report_collector: stimulus queues expected
// events, a negedge monitor compares the FIFO head against the queue.
module tb_ltl_report_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  report_in;
    logic [3:0]  report_mask;
    logic        clear_sticky;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_report;
    logic [31:0] evt_index;
    logic [3:0]  sticky;
    logic [15:0] overflow_cnt;
    logic [3:0]  fifo_level;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] sb [$];

    ltl_report_collector #(
        .NUM_REPORTS(4),
        .FIFO_DEPTH(8),
        .IDX_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .report_in(report_in),
        .report_mask(report_mask),
        .clear_sticky(clear_sticky),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_report(evt_report),
        .evt_index(evt_index),
        .sticky(sticky),
        .overflow_cnt(overflow_cnt),
        .fifo_level(fifo_level),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [3:0] rep, input logic [31:0] idx);
        sb.push_back({rep, idx});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        run          = 1'b0;
        report_in    = '0;
        clear_sticky = 1'b0;
        evt_ready    = 1'b0;
        sb.delete();
        step();
        reset = 1'b0;
    endtask

    task automatic drive(input logic r, input logic [3:0] rep,
                         input logic rdy);
        run       = r;
        report_in = rep;
        evt_ready = rdy;
        step();
    endtask

    // Head must match the oldest expected entry whenever it is valid
    always @(negedge clk) begin
        if (!reset && evt_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_evt", {28'd0, evt_report, evt_index}, 64'd0);
            end else begin
                chk("evt_report", 64'(evt_report), 64'(sb[0][35:32]));
                chk("evt_index", 64'(evt_index), 64'(sb[0][31:0]));
                if (evt_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        report_mask = 4'hF;
        do_reset();
        do_reset();
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_sticky", 64'(sticky), 64'd0);
        chk("rst_ovf", 64'(overflow_cnt), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_report", 64'(evt_report), 64'd0);
        chk("rst_index", 64'(evt_index), 64'd0);

        // basic hit: report 0x2 arrives for symbol 2
        for (int i = 0; i < 7; i++) begin
            if (i == 3) expect_evt(4'h2, 32'd2);
            drive(i < 5, (i == 3) ? 4'h2 : 4'h0, 1'b0);
        end
        chk("basic_sticky", 64'(sticky), 64'h2);
        chk("basic_irq", 64'(irq), 64'd1);
        chk("basic_level", 64'(fifo_level), 64'd1);
        drive(1'b0, 4'h0, 1'b1);
        evt_ready = 1'b0;
        chk("basic_drained", 64'(evt_valid), 64'd0);

        clear_sticky = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        clear_sticky = 1'b0;
        chk("clear_sticky", 64'(sticky), 64'd0);

        // masking and run gating
        report_mask = 4'h5;
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b0, 4'hA, 1'b0);
        report_mask = 4'hF;
        drive(1'b0, 4'hF, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        chk("mask_level", 64'(fifo_level), 64'd0);
        chk("mask_sticky", 64'(sticky), 64'd0);

        // overflow: 10 hits into 8 entries
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i >= 1 && i <= 8) expect_evt(4'h1, 32'(i - 1));
            drive(i < 10, (i >= 1) ? 4'h1 : 4'h0, 1'b0);
        end
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_cnt", 64'(overflow_cnt), 64'd2);

        // full with push and pop together
        drive(1'b1, 4'h0, 1'b0);
        expect_evt(4'h1, 32'd10);
        drive(1'b0, 4'h1, 1'b1);
        chk("fullpp_level", 64'(fifo_level), 64'd8);
        chk("fullpp_ovf", 64'(overflow_cnt), 64'd2);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'h0, 1'b1);
        evt_ready = 1'b0;
        chk("drain_valid", 64'(evt_valid), 64'd0);
        chk("drain_level", 64'(fifo_level), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);

        // sticky set beats clear
        do_reset();
        expect_evt(4'h8, 32'd0);
        expect_evt(4'h1, 32'd1);
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b1, 4'h8, 1'b0);
        chk("race_pre", 64'(sticky), 64'h8);
        clear_sticky = 1'b1;
        drive(1'b0, 4'h1, 1'b0);
        chk("race_sticky", 64'(sticky), 64'h1);
        chk("race_irq", 64'(irq), 64'd1);
        drive(1'b0, 4'h0, 1'b0);
        clear_sticky = 1'b0;
        chk("race_clr", 64'(sticky), 64'd0);
        chk("race_irq_clr", 64'(irq), 64'd0);
        drive(1'b0, 4'h0, 1'b1);
        drive(1'b0, 4'h0, 1'b1);
        evt_ready = 1'b0;
        chk("race_sb", 64'(sb.size()), 64'd0);

        // reset mid-stream
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i >= 1 && i <= 3) expect_evt(4'h1, 32'(i - 1));
            drive(1'b1, (i >= 1 && i <= 3) ? 4'h1 : 4'h0, 1'b0);
        end
        chk("mid_level", 64'(fifo_level), 64'd3);
        do_reset();
        chk("mid_valid", 64'(evt_valid), 64'd0);
        chk("mid_lvl0", 64'(fifo_level), 64'd0);
        chk("mid_sticky", 64'(sticky), 64'd0);
        chk("mid_ovf", 64'(overflow_cnt), 64'd0);
        drive(1'b1, 4'hF, 1'b0);
        chk("mid_ignored", 64'(fifo_level), 64'd0);
        expect_evt(4'h4, 32'd0);
        drive(1'b0, 4'h4, 1'b0);
        chk("mid_newlvl", 64'(fifo_level), 64'd1);
        drive(1'b0, 4'h0, 1'b1);
        evt_ready = 1'b0;
        step();
        chk("end_sb", 64'(sb.size()), 64'd0);
        chk("end_valid", 64'(evt_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Sits directly downstream of a generated LTL automaton cluster in the monitor.
- Consumes the cluster's report lines, which are the active_state outputs of its report STEs.
- Tags each masked report hit with the index of the symbol that caused it, and buffers hits in a first-word-fall-through FIFO for the host/debug read-out.
- Keeps per-report sticky violation flags, an overflow counter and an interrupt.

Parameters:
NUM_REPORTS, 4, number of report lines from the automaton cluster
FIFO_DEPTH, 8, event FIFO entries; power of 2, >= 2
IDX_W, 32, width of the symbol index counter and event index field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  same run strobe driven to the automaton; high = a symbol is consumed this cycle
report_in  in  NUM_REPORTS  automaton report lines (registered STE active_state)
report_mask  in  NUM_REPORTS  per-report enable; 1 = collected
clear_sticky  in  1  one-cycle pulse; clears sticky
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_report  out  NUM_REPORTS  masked report vector of head entry
evt_index  out  IDX_W  symbol index of head entry
sticky  out  NUM_REPORTS  accumulated masked reports since last clear/reset
overflow_cnt  out  16  dropped-event count, saturating
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
irq  out  1  high while any sticky bit is set

Behaviour:
- Reset values: all outputs are 0, sym_cnt=0, run_d=0, and the FIFO is empty.
- Symbol counter:
  - sym_cnt increments by 1 on every cycle with run=1.
  - It wraps modulo 2^IDX_W with no flag.
  - The first consumed symbol has index 0.
- Alignment: report_in reflects the symbol consumed one cycle earlier.
  - Registers: run_d<=run and idx_d<=sym_cnt, both every cycle.
  - A report is considered only when run_d=1.
- Hit detection: m = report_in & report_mask; hit = run_d & |m.
- Push: on hit, the entry {m, idx_d} is written to the FIFO tail in that cycle. The entry is visible at the head no earlier than the next cycle.
- Pop: a pop occurs when evt_valid & evt_ready.
  - evt_report/evt_index present the head entry combinationally from storage.
  - evt_valid = (level != 0).
  - Head outputs must hold stable while evt_valid=1 and evt_ready=0.
- FIFO full:
  - Full, hit, no pop: the entry is dropped and overflow_cnt increments, saturating at 0xFFFF.
  - Full, hit, pop in the same cycle: the push is accepted and the level is unchanged.
- FIFO empty with a push in the same cycle: a pop is impossible, because evt_valid=0.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Sticky:
  - Update rule: sticky <= (clear_sticky ? 0 : sticky) | (hit ? m : 0).
  - If a set and a clear occur in the same cycle, the set wins.
  - Sticky is unaffected by FIFO overflow.
- irq = |sticky, driven from register outputs (no combinational path from report_in).
- Masking:
  - report_mask is sampled in the same cycle as report_in.
  - A hit whose masked vector is all-zero is not a hit.
- Reset mid-operation:
  - All state clears, FIFO contents are discarded, and overflow_cnt=0.
  - The report_in cycle immediately after reset deassertion is ignored, because run_d=0.
- No combinational path from evt_ready to evt_valid.

Test Plan:
- Basic hit: mask=0xF; run=1 for 5 cycles; report_in=0x2 one cycle after the 3rd symbol -> one entry {report=0x2, index=2}; sticky=0x2, irq=1, fifo_level=1.
- Mask and run gating:
  - mask=0x5 with report_in=0xA while run_d=1 -> no push, sticky=0.
  - report_in=0xF with run_d=0 -> no push.
- Overflow: FIFO_DEPTH=8, evt_ready=0, 10 consecutive hits -> fifo_level=8, overflow_cnt=2; drain yields indices in order and evt_valid falls after 8 pops.
- Full with simultaneous push and pop: fill to 8, then hit with evt_ready=1 -> level stays 8, overflow_cnt unchanged, new entry lands at the tail.
- Sticky race: clear_sticky=1 in the same cycle as a hit with m=0x1 while sticky=0x8 -> sticky=0x1, irq stays 1; next cycle clear with no hit -> sticky=0, irq=0.
- Reset mid-stream: 3 entries queued, sym_cnt=20, reset for 1 cycle -> evt_valid=0, level=0, sticky=0; next consumed symbol is tagged index 0.
